// File: rtl/disp_pkg.sv
// Shared state encoding, dash frame constant and default timing parameters
// for the display refresh scheduler (display_sched, disp_rr_arb).
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } disp_state_t;

    localparam logic [15:0] DASH_FRAME = 16'hAAAA;

    localparam int DEF_REFRESH_CYCLES = 50000;
    localparam int DEF_LATCH_CYCLES   = 2;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/disp_rr_arb.sv
// Two-requester round-robin arbiter: requester a wins the first tie after
// reset, and after any accepted grant the other requester gets tie priority.
module disp_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic grant_a,
    output logic grant_b
);

    logic prio_b;

    always_comb begin
        grant_a = req_a & (~req_b | ~prio_b);
        grant_b = req_b & (~req_a | prio_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_b <= 1'b0;
        end else if (advance && (grant_a || grant_b)) begin
            prio_b <= grant_a;
        end
    end

endmodule

// File: rtl/display_sched.sv
// Display frame scheduler: captures operand/result BCD frames, drives the
// serializer, pulses the display latch and re-sends the frame periodically.
// Optional error-display mode (err_req/err_clr) is built when DISP_ERR_EN is defined.
module display_sched
    import disp_pkg::*;
#(
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_entry,
    input  logic [15:0] bcd_entry,
    output logic        ack_entry,
    input  logic        req_result,
    input  logic [15:0] bcd_result,
    output logic        ack_result,
`ifdef DISP_ERR_EN
    input  logic        err_req,
    input  logic        err_clr,
`endif
    input  logic        ser_done,
    output logic        ser_en,
    output logic [15:0] ser_bcd,
    output logic        latch,
    output logic        busy,
    output logic        timeout_err
);

    localparam int RW = cnt_width(REFRESH_CYCLES);
    localparam int PW = cnt_width((TIMEOUT_CYCLES > LATCH_CYCLES) ? TIMEOUT_CYCLES : LATCH_CYCLES);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [PW-1:0] TIMEOUT_LAST = PW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] LATCH_LAST   = PW'(LATCH_CYCLES - 1);

    disp_state_t   state, state_next;
    logic [RW-1:0] refresh_cnt;
    logic [PW-1:0] phase_cnt;
    logic [15:0]   frame_reg;
    logic          frame_valid;
    logic          idle;
    logic          arb_req_entry, arb_req_result;
    logic          grant_entry, grant_result;
    logic          take_entry, take_result;
    logic          timeout_hit, latch_done;

    // Error mode masks both requesters so only refreshes of the dash frame run.
`ifdef DISP_ERR_EN
    logic err_mode, take_err;
    assign arb_req_entry  = req_entry  & ~(err_mode | err_req);
    assign arb_req_result = req_result & ~(err_mode | err_req);
`else
    assign arb_req_entry  = req_entry;
    assign arb_req_result = req_result;
`endif

    assign idle = (state == ST_IDLE);

    disp_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_a   (arb_req_entry),
        .req_b   (arb_req_result),
        .advance (idle),
        .grant_a (grant_entry),
        .grant_b (grant_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        take_entry  = 1'b0;
        take_result = 1'b0;
        timeout_hit = 1'b0;
        latch_done  = 1'b0;
`ifdef DISP_ERR_EN
        take_err    = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
`ifdef DISP_ERR_EN
                if (err_req) begin
                    take_err   = 1'b1;
                    state_next = ST_SEND;
                end else
`endif
                if (grant_entry) begin
                    take_entry = 1'b1;
                    state_next = ST_SEND;
                end else if (grant_result) begin
                    take_result = 1'b1;
                    state_next  = ST_SEND;
                end else if (frame_valid && refresh_cnt == REFRESH_LAST) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ser_done) begin
                    state_next = ST_LATCH;
                end else if (phase_cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (phase_cnt == LATCH_LAST) begin
                    latch_done = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ack_entry  = take_entry;
    assign ack_result = take_result;
    assign ser_en     = (state == ST_SEND);
    assign latch      = (state == ST_LATCH);
    assign busy       = ~idle;
    assign ser_bcd    = frame_reg;

    // phase_cnt times SEND and LATCH; refresh_cnt only advances while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            phase_cnt   <= '0;
            frame_reg   <= '0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
`ifdef DISP_ERR_EN
            err_mode    <= 1'b0;
`endif
        end else begin
            if (state_next != state) begin
                phase_cnt <= '0;
            end else if (!idle) begin
                phase_cnt <= phase_cnt + 1'b1;
            end

            if (idle && state_next == ST_SEND) begin
                refresh_cnt <= '0;
            end else if (idle && refresh_cnt != REFRESH_LAST) begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end

            if (take_entry) begin
                frame_reg   <= bcd_entry;
                frame_valid <= 1'b1;
            end
            if (take_result) begin
                frame_reg   <= bcd_result;
                frame_valid <= 1'b1;
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (latch_done) begin
                timeout_err <= 1'b0;
            end
`ifdef DISP_ERR_EN
            if (take_err) begin
                frame_reg   <= DASH_FRAME;
                frame_valid <= 1'b1;
                err_mode    <= 1'b1;
            end
            if (err_clr) begin
                err_mode    <= 1'b0;
                frame_valid <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_display_sched.sv
// Self-checking bench for display_sched: directed scenarios plus randomized
// request/serializer traffic against a transaction-level reference model.
module tb_display_sched;

    localparam int REFRESH = 100;
    localparam int LATCHW  = 2;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_entry = 1'b0, req_result = 1'b0;
    logic [15:0] bcd_entry = '0, bcd_result = '0;
    logic        ack_entry, ack_result;
    logic        ser_done = 1'b0;
    logic        ser_en, latch, busy, timeout_err;
    logic [15:0] ser_bcd;
`ifdef DISP_ERR_EN
    logic        err_req = 1'b0, err_clr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: last frame sent, whether one exists, who was served
    // last (0 entry, 1 result) and the expected sticky timeout flag.
    bit          model_valid;
    logic [15:0] model_frame;
    int          last_served;
    bit          model_tout;

    display_sched #(
        .REFRESH_CYCLES (REFRESH),
        .LATCH_CYCLES   (LATCHW),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_entry   (req_entry),
        .bcd_entry   (bcd_entry),
        .ack_entry   (ack_entry),
        .req_result  (req_result),
        .bcd_result  (bcd_result),
        .ack_result  (ack_result),
`ifdef DISP_ERR_EN
        .err_req     (err_req),
        .err_clr     (err_clr),
`endif
        .ser_done    (ser_done),
        .ser_en      (ser_en),
        .ser_bcd     (ser_bcd),
        .latch       (latch),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_valid = 1'b0;
        model_frame = '0;
        last_served = 1;
        model_tout  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
    endtask

    // Idle until SEND appears; the requester drops req after seeing its ack.
    task automatic wait_send(output int gap, output int n_ack_e, output int n_ack_r);
        gap = 0;
        n_ack_e = 0;
        n_ack_r = 0;
        while (!ser_en && gap < 400) begin
            bit saw_e, saw_r;
            saw_e = ack_entry;
            saw_r = ack_result;
            n_ack_e += int'(saw_e);
            n_ack_r += int'(saw_r);
            gap++;
            @(negedge clk);
            if (saw_e) req_entry = 1'b0;
            if (saw_r) req_result = 1'b0;
            #1;
        end
    endtask

    // Play serializer: raise ser_done on SEND cycle 'delay' (never if beyond timeout).
    task automatic finish_send(input int delay, input logic [15:0] exp_bcd);
        int n_send = 0;
        int n_latch = 0;
        int acks = 0;
        bit bcd_ok = 1'b1;
        bit exp_tout;
        check_output("tout_sticky", 32'(timeout_err), 32'(model_tout));
        while (ser_en && n_send < 100) begin
            if (ser_bcd !== exp_bcd) bcd_ok = 1'b0;
            acks += int'(ack_entry) + int'(ack_result);
            n_send++;
            if (n_send == delay) ser_done = 1'b1;
            @(negedge clk);
            ser_done = 1'b0;
            #1;
        end
        while (latch && n_latch < 10) begin
            acks += int'(ack_entry) + int'(ack_result);
            n_latch++;
            @(negedge clk);
            #1;
        end
        exp_tout = (delay > TIMEOUT);
        check_output("send_len", n_send, exp_tout ? TIMEOUT : delay);
        check_output("latch_len", n_latch, exp_tout ? 0 : LATCHW);
        check_output("bcd_stable", 32'(bcd_ok), 32'd1);
        check_output("acks_busy", acks, 0);
        check_output("busy_end", 32'(busy), 32'd0);
        check_output("tout_end", 32'(timeout_err), 32'(exp_tout));
        model_tout = exp_tout;
    endtask

    // One frame: optionally raise new requests, predict winner, data, gap and acks.
    task automatic apply_stimulus(input bit new_e, input logic [15:0] de,
                                  input bit new_r, input logic [15:0] dr, input int delay);
        int win;
        int exp_gap;
        int gap, ne, nr;
        logic [15:0] exp_data;
        if (new_e && !req_entry) begin
            req_entry = 1'b1;
            bcd_entry = de;
        end
        if (new_r && !req_result) begin
            req_result = 1'b1;
            bcd_result = dr;
        end
        if (req_entry && req_result) win = (last_served == 1) ? 0 : 1;
        else if (req_entry)          win = 0;
        else if (req_result)         win = 1;
        else                         win = 2;
        exp_data = (win == 0) ? bcd_entry : (win == 1) ? bcd_result : model_frame;
        exp_gap  = (win == 2) ? REFRESH : 1;
        #1;
        wait_send(gap, ne, nr);
        check_output("idle_gap", gap, exp_gap);
        check_output("ser_en_on", 32'(ser_en), 32'd1);
        check_output("ser_bcd", 32'(ser_bcd), 32'(exp_data));
        check_output("ack_entry_cnt", ne, (win == 0) ? 1 : 0);
        check_output("ack_result_cnt", nr, (win == 1) ? 1 : 0);
        if (win != 2) last_served = win;
        model_frame = exp_data;
        model_valid = 1'b1;
        finish_send(delay, exp_data);
    endtask

    initial begin
        int gap, ne, nr, quiet;
        model_reset();

        rst = 1'b1;
        #1;
        check_output("rst_ser_en", 32'(ser_en), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_latch", 32'(latch), 32'd0);
        check_output("rst_ser_bcd", 32'(ser_bcd), 32'd0);
        check_output("rst_tout", 32'(timeout_err), 32'd0);
        apply_reset();

        $display("[TB] tie between entry and result");
        apply_stimulus(1'b1, 16'h1111, 1'b1, 16'h2222, 3);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 3);

        $display("[TB] single entry frame and refresh");
        apply_stimulus(1'b1, 16'h1234, 1'b0, 16'h0000, 3);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 2);

        $display("[TB] timeout and recovery");
        apply_stimulus(1'b1, 16'h0042, 1'b0, 16'h0000, TIMEOUT + 1);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000, 2);
        apply_stimulus(1'b0, 16'h0000, 1'b1, 16'h0777, TIMEOUT);
        apply_stimulus(1'b0, 16'h0000, 1'b0, 16'h0000, TIMEOUT + 3);

        $display("[TB] reset during SEND");
        req_entry = 1'b1;
        bcd_entry = 16'h5678;
        #1;
        wait_send(gap, ne, nr);
        check_output("pre_rst_gap", gap, 1);
        @(negedge clk);
        #1;
        check_output("pre_rst_ser_en", 32'(ser_en), 32'd1);
        check_output("pre_rst_tout", 32'(timeout_err), 32'd1);
        rst = 1'b1;
        #1;
        check_output("mid_rst_ser_en", 32'(ser_en), 32'd0);
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_ser_bcd", 32'(ser_bcd), 32'd0);
        check_output("mid_rst_tout", 32'(timeout_err), 32'd0);
        check_output("mid_rst_latch", 32'(latch), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        quiet = 0;
        for (int i = 0; i < REFRESH + 50; i++) begin
            quiet += int'(busy);
            @(negedge clk);
            #1;
        end
        check_output("no_refresh_after_rst", quiet, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 30; i++) begin
            bit new_e, new_r;
            int d;
            new_e = ($urandom_range(0, 1) == 1);
            new_r = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 5) == 0) d = TIMEOUT + 1 + int'($urandom_range(0, 3));
            else                           d = int'($urandom_range(1, 8));
            if (!model_valid && !new_e && !new_r && !req_entry && !req_result) new_e = 1'b1;
            apply_stimulus(new_e, 16'($urandom), new_r, 16'($urandom), d);
        end

`ifdef DISP_ERR_EN
        $display("[TB] error display mode");
        apply_reset();
        req_result = 1'b1;
        bcd_result = 16'h2468;
        err_req = 1'b1;
        #1;
        check_output("err_ack_withheld", 32'(ack_result), 32'd0);
        wait_send(gap, ne, nr);
        err_req = 1'b0;
        check_output("err_gap", gap, 1);
        check_output("err_bcd", 32'(ser_bcd), 32'hAAAA);
        check_output("err_no_ack", nr + ne, 0);
        finish_send(2, 16'hAAAA);
        wait_send(gap, ne, nr);
        check_output("err_refresh_gap", gap, REFRESH);
        check_output("err_refresh_bcd", 32'(ser_bcd), 32'hAAAA);
        check_output("err_refresh_no_ack", nr + ne, 0);
        finish_send(2, 16'hAAAA);
        err_clr = 1'b1;
        #1;
        check_output("err_clr_cycle_ack", 32'(ack_result), 32'd0);
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        wait_send(gap, ne, nr);
        check_output("post_clr_gap", gap, 1);
        check_output("post_clr_ack", nr, 1);
        check_output("post_clr_bcd", 32'(ser_bcd), 32'h2468);
        finish_send(2, 16'h2468);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
